// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer (seq/branch/jump/call/ret/irq/halt -> pc_next, pc_wrt_s2, flush, irq_ack, epc, halted, ras_err); define RAS_EN for the return-address stack
module pc_seq_ctrl #(
  parameter logic [15:0] RST_VEC   = 16'h0000,
  parameter logic [15:0] IRQ_VEC   = 16'h0010,
  parameter logic [15:0] INC       = 16'd1,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_cur,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        jmp,
  input  logic [15:0] jmp_target,
  input  logic        call,
  input  logic        ret,
  input  logic        reti,
  input  logic        halt,
  input  logic        irq,
  output logic [15:0] pc_next,
  output logic        pc_wrt_s2,
  output logic        flush,
  output logic        irq_ack,
  output logic [15:0] epc,
  output logic        halted,
  output logic        ras_err
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_n;
  logic ie, ie_n;
  logic [15:0] epc_n, seq;
  assign seq = pc_cur + INC;
`ifdef RAS_EN
  localparam int PW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
  localparam int LAST_I = RAS_DEPTH - 1;
  localparam logic [PW-1:0] LAST = LAST_I[PW-1:0];
  localparam logic [PW:0] FULL = RAS_DEPTH[PW:0];
  logic [15:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr, ptr_inc, ptr_dec;
  logic [PW:0] cnt;
  logic push, pop, ras_full, ras_empty;
  assign ptr_inc = ptr == LAST ? '0 : ptr + 1'b1;
  assign ptr_dec = ptr == '0 ? LAST : ptr - 1'b1;
  assign ras_full = cnt == FULL;
  assign ras_empty = cnt == '0;
  always_ff @(posedge clk)
    if (!rst && push) ras[ptr] <= seq;
  // a full push overwrites the oldest slot, so the count saturates while ptr keeps rotating
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      cnt <= ras_full ? cnt : cnt + 1'b1;
    end else if (pop) begin
      ptr <= ptr_dec;
      cnt <= cnt - 1'b1;
    end
`else
  localparam int unused_ras_depth = RAS_DEPTH;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= BOOT;
      ie <= 1'b0;
      epc <= '0;
    end else begin
      state <= state_n;
      ie <= ie_n;
      epc <= epc_n;
    end
  assign halted = state == HALT && !rst;
  always_comb begin
    state_n = state;
    ie_n = ie;
    epc_n = epc;
    pc_next = seq;
    pc_wrt_s2 = 1'b0;
    flush = 1'b0;
    irq_ack = 1'b0;
    ras_err = 1'b0;
`ifdef RAS_EN
    push = 1'b0;
    pop = 1'b0;
`endif
    if (rst) begin
      pc_next = RST_VEC;
    end else if (state == BOOT) begin
      pc_next = RST_VEC;
      pc_wrt_s2 = 1'b1;
      flush = 1'b1;
      state_n = RUN;
      ie_n = 1'b1;
    end else if (state == HALT ? irq : (!halt && irq && ie)) begin
      epc_n = pc_cur;
      ie_n = 1'b0;
      pc_next = IRQ_VEC;
      pc_wrt_s2 = 1'b1;
      flush = 1'b1;
      irq_ack = 1'b1;
      state_n = RUN;
    end else if (state == HALT) begin
      state_n = HALT;
    end else if (halt) begin
      flush = 1'b1;
      state_n = HALT;
    end else if (reti) begin
      pc_next = epc;
      ie_n = 1'b1;
      pc_wrt_s2 = 1'b1;
      flush = 1'b1;
`ifdef RAS_EN
    end else if (call) begin
      pc_next = jmp_target;
      pc_wrt_s2 = 1'b1;
      flush = 1'b1;
      push = 1'b1;
      ras_err = ras_full;
    end else if (ret) begin
      pc_next = ras_empty ? seq : ras[ptr_dec];
      pc_wrt_s2 = 1'b1;
      flush = !ras_empty;
      pop = !ras_empty;
      ras_err = ras_empty;
`endif
    end else if (jmp || call) begin
      pc_next = jmp_target;
      pc_wrt_s2 = 1'b1;
      flush = 1'b1;
`ifndef RAS_EN
    end else if (ret) begin
      pc_wrt_s2 = !stall;
`endif
    end else if (br_taken) begin
      pc_next = br_target;
      pc_wrt_s2 = 1'b1;
      flush = 1'b1;
    end else begin
      pc_wrt_s2 = !stall;
    end
  end
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: scoreboard bench for pc_seq_ctrl against a behavioural next-PC model
module tb_pc_seq_ctrl;
  logic clk = 1'b1;
  logic rst, stall, br_taken, jmp, call, ret, reti, halt, irq;
  logic [15:0] pc_cur, br_target, jmp_target;
  logic [15:0] pc_next, epc;
  logic pc_wrt_s2, flush, irq_ack, halted, ras_err;
  always #5 clk = ~clk;
  pc_seq_ctrl dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target), .call(call), .ret(ret),
    .reti(reti), .halt(halt), .irq(irq), .pc_next(pc_next), .pc_wrt_s2(pc_wrt_s2),
    .flush(flush), .irq_ack(irq_ack), .epc(epc), .halted(halted), .ras_err(ras_err)
  );
  typedef struct {
    logic [15:0] pc, epc;
    logic chk_pc, chk_epc, wrt, flush, ack, halted, err;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  bit m_boot = 1'b1, m_halt = 1'b0, m_ie = 1'b0, m_epc_ok = 1'b0;
  logic [15:0] m_epc = 16'h0, pcv = 16'h0;
  logic [15:0] ras_q[$];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk_pc) chk("pc_next", pc_next, e.pc);
      chk("pc_wrt_s2", {15'd0, pc_wrt_s2}, {15'd0, e.wrt});
      chk("flush", {15'd0, flush}, {15'd0, e.flush});
      chk("irq_ack", {15'd0, irq_ack}, {15'd0, e.ack});
      chk("halted", {15'd0, halted}, {15'd0, e.halted});
      chk("ras_err", {15'd0, ras_err}, {15'd0, e.err});
      if (e.chk_epc) chk("epc", epc, e.epc);
    end
  task automatic clr();
    {stall, br_taken, jmp, call, ret, reti, halt, irq} = '0;
  endtask
  task automatic tick();
    exp_t e;
    logic [15:0] seq;
    seq = pcv + 16'd1;
    pc_cur = pcv;
    e.pc = seq;
    e.epc = m_epc;
    e.chk_epc = m_epc_ok;
    {e.wrt, e.flush, e.ack, e.halted, e.err} = '0;
    if (rst) begin
      e.pc = 16'h0000;
      m_boot = 1'b1; m_halt = 1'b0; m_ie = 1'b0; m_epc = 16'h0; m_epc_ok = 1'b1;
      ras_q.delete();
    end else if (m_boot) begin
      e.pc = 16'h0000; e.wrt = 1'b1; e.flush = 1'b1;
      m_boot = 1'b0; m_ie = 1'b1;
    end else if (m_halt ? irq : (!halt && irq && m_ie)) begin
      e.halted = m_halt;
      e.pc = 16'h0010; e.wrt = 1'b1; e.flush = 1'b1; e.ack = 1'b1;
      m_epc = pcv; m_ie = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      e.halted = 1'b1;
    end else if (halt) begin
      e.flush = 1'b1; m_halt = 1'b1;
    end else if (reti) begin
      e.pc = m_epc; e.wrt = 1'b1; e.flush = 1'b1; m_ie = 1'b1;
`ifdef RAS_EN
    end else if (call) begin
      e.pc = jmp_target; e.wrt = 1'b1; e.flush = 1'b1;
      ras_q.push_back(seq);
      if (ras_q.size() > 4) begin
        void'(ras_q.pop_front());
        e.err = 1'b1;
      end
    end else if (ret) begin
      e.wrt = 1'b1;
      if (ras_q.size() == 0) e.err = 1'b1;
      else begin
        e.pc = ras_q.pop_back();
        e.flush = 1'b1;
      end
`endif
    end else if (call || jmp) begin
      e.pc = jmp_target; e.wrt = 1'b1; e.flush = 1'b1;
`ifndef RAS_EN
    end else if (ret) begin
      e.wrt = !stall;
`endif
    end else if (br_taken) begin
      e.pc = br_target; e.wrt = 1'b1; e.flush = 1'b1;
    end else begin
      e.wrt = !stall;
    end
    e.chk_pc = e.wrt || rst;
    if (e.wrt) pcv = e.pc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
  initial begin
    clr();
    br_target = 16'h0; jmp_target = 16'h0; pc_cur = 16'h0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    pcv = 16'h0005; stall = 1'b1; br_taken = 1'b1; br_target = 16'h0040;
    tick(); clr();
    pcv = 16'h0020; irq = 1'b1;
    tick(); tick(); tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick(); clr();
    pcv = 16'hFFFF;
    tick();
    pcv = 16'h0030; halt = 1'b1;
    tick(); halt = 1'b0;
    repeat (10) tick();
    irq = 1'b1;
    tick(); clr();
    tick();
    reti = 1'b1;
    tick(); clr();
    jmp_target = 16'h0200;
    for (int i = 0; i < 5; i++) begin
      pcv = 16'h0100 + 16'(i); call = 1'b1;
      tick();
    end
    clr();
    pcv = 16'h0300;
    for (int i = 0; i < 5; i++) begin
      ret = 1'b1;
      tick();
    end
    clr();
    repeat (600) begin
      rst = $urandom_range(63) == 0;
      halt = $urandom_range(39) == 0;
      irq = $urandom_range(7) == 0;
      reti = $urandom_range(9) == 0;
      call = $urandom_range(7) == 0;
      ret = $urandom_range(7) == 0;
      jmp = $urandom_range(9) == 0;
      br_taken = $urandom_range(5) == 0;
      stall = $urandom_range(3) == 0;
      br_target = 16'($urandom);
      jmp_target = 16'($urandom);
      if ($urandom_range(15) == 0) pcv = 16'($urandom);
      tick();
    end
    rst = 1'b0; clr();
    tick();
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
